upsp_pixel_serializer: RTL and testbench



---
 rtl/upsp_pkg.sv | 16 +
 rtl/upsp_bundle_fifo.sv | 54 +++++
 rtl/upsp_pixel_serializer.sv | 111 +++++++++++
 tb/tb_upsp_pixel_serializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/upsp_pkg.sv
// Shared types and helpers for the upscaler pixel serializer.
package upsp_pkg;

    localparam int PIXEL_WIDTH  = 24;
    localparam int PIX_PER_BEAT = 4;
    localparam int BEAT_W       = $clog2(PIX_PER_BEAT);

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef pixel_t [PIX_PER_BEAT-1:0] bundle_t;

    // Pixel 0 sits in the most significant slot of the bundle.
    function automatic pixel_t pix_sel(input bundle_t bundle, input logic [BEAT_W-1:0] idx);
        return bundle[BEAT_W'(PIX_PER_BEAT-1) - idx];
    endfunction

endpackage

// File: rtl/upsp_bundle_fifo.sv
// Generic synchronous FIFO with single-cycle push/pop and an occupancy count.
module upsp_bundle_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/upsp_pixel_serializer.sv
// Splits 4-pixel bundles into a 24-bit pixel stream with line/frame markers.
// Optional stall counters are built when UPSP_SER_PERF_CNT_EN is defined.
module upsp_pixel_serializer #(
    parameter int PIXEL_WIDTH  = 24,
    parameter int PIX_PER_BEAT = 4,
    parameter int DST_WIDTH    = 3840,
    parameter int DST_HEIGHT   = 2160,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PIXEL_WIDTH*PIX_PER_BEAT-1:0] upsp_ac_wdata,
    input  logic                            upsp_ac_wvalid,
    output logic                            ac_upsp_wready,
    output logic [PIXEL_WIDTH-1:0]          m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            m_tuser,
    output logic                            frame_done
`ifdef UPSP_SER_PERF_CNT_EN
    ,
    output logic [31:0]                     stall_in_cnt,
    output logic [31:0]                     stall_out_cnt
`endif
);

    import upsp_pkg::*;

    localparam int COL_W  = $clog2(DST_WIDTH);
    localparam int ROW_W  = $clog2(DST_HEIGHT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_N = $clog2(PIX_PER_BEAT);

    logic [PIXEL_WIDTH*PIX_PER_BEAT-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic [BEAT_N-1:0] beat;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              push;
    logic              pop;
    logic              handshake;
    logic              last_col;
    logic              last_row;

    // Ready looks only at registered occupancy, so m_tready never reaches it.
    assign ac_upsp_wready = ~rst & (count != CNT_W'(FIFO_DEPTH));
    assign push           = upsp_ac_wvalid & ac_upsp_wready & ~full;
    assign m_tvalid       = ~empty;
    assign handshake      = m_tvalid & m_tready;
    assign pop            = handshake & (beat == BEAT_N'(PIX_PER_BEAT-1));
    assign last_col       = (col == COL_W'(DST_WIDTH-1));
    assign last_row       = (row == ROW_W'(DST_HEIGHT-1));

    assign m_tdata = m_tvalid ? pix_sel(bundle_t'(head), beat) : '0;
    assign m_tlast = m_tvalid & last_col;
    assign m_tuser = m_tvalid & (col == '0) & (row == '0);

    upsp_bundle_fifo #(
        .WIDTH (PIXEL_WIDTH*PIX_PER_BEAT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (upsp_ac_wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            beat       <= '0;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= handshake & last_col & last_row;
            if (handshake) begin
                beat <= beat + 1'b1;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

`ifdef UPSP_SER_PERF_CNT_EN
    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_in_cnt  <= '0;
            stall_out_cnt <= '0;
        end else begin
            if (upsp_ac_wvalid & ~ac_upsp_wready & (stall_in_cnt != '1))
                stall_in_cnt <= stall_in_cnt + 1'b1;
            if (m_tvalid & ~m_tready & (stall_out_cnt != '1))
                stall_out_cnt <= stall_out_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_upsp_pixel_serializer.sv
// Self-checking bench for upsp_pixel_serializer (small 8x2 frame).
module tb_upsp_pixel_serializer;

    localparam int DW    = 8;
    localparam int DH    = 2;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] upsp_ac_wdata;
    logic        upsp_ac_wvalid;
    logic        ac_upsp_wready;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic        frame_done;
`ifdef UPSP_SER_PERF_CNT_EN
    logic [31:0] stall_in_cnt;
    logic [31:0] stall_out_cnt;
`endif

    always #5 clk = ~clk;

    upsp_pixel_serializer #(
        .PIXEL_WIDTH  (24),
        .PIX_PER_BEAT (4),
        .DST_WIDTH    (DW),
        .DST_HEIGHT   (DH),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .upsp_ac_wdata  (upsp_ac_wdata),
        .upsp_ac_wvalid (upsp_ac_wvalid),
        .ac_upsp_wready (ac_upsp_wready),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .m_tuser        (m_tuser),
        .frame_done     (frame_done)
`ifdef UPSP_SER_PERF_CNT_EN
        ,
        .stall_in_cnt   (stall_in_cnt),
        .stall_out_cnt  (stall_out_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic [95:0] wdata;
        logic        wvalid;
        logic        tready;
        logic [23:0] exp_data;
        logic        exp_valid;
        logic        exp_last;
        logic        exp_user;
        logic        exp_wready;
    } vec_t;

    vec_t vecs [7];

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    // Reference model state: queued bundles, beat, position, pending pulse.
    logic [95:0] mq [$];
    int          m_beat = 0;
    int          m_col  = 0;
    int          m_row  = 0;
    bit          m_fd   = 1'b0;
    logic [31:0] m_sin  = '0;
    logic [31:0] m_sout = '0;
    bit          last_hs;
    bit          last_push;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        rst            = v.rst;
        upsp_ac_wdata  = v.wdata;
        upsp_ac_wvalid = v.wvalid;
        m_tready       = v.tready;
        #1;
        checkOutput($sformatf("vec%0d.m_tdata", idx),        32'(m_tdata),        32'(v.exp_data));
        checkOutput($sformatf("vec%0d.m_tvalid", idx),       32'(m_tvalid),       32'(v.exp_valid));
        checkOutput($sformatf("vec%0d.m_tlast", idx),        32'(m_tlast),        32'(v.exp_last));
        checkOutput($sformatf("vec%0d.m_tuser", idx),        32'(m_tuser),        32'(v.exp_user));
        checkOutput($sformatf("vec%0d.ac_upsp_wready", idx), 32'(ac_upsp_wready), 32'(v.exp_wready));
    endtask

    function automatic logic [95:0] make_bundle(input int k);
        logic [95:0] b;
        b = '0;
        for (int j = 0; j < 4; j++) b[95-24*j -: 24] = {16'(k), 8'(j + 1)};
        return b;
    endfunction

    // Compare every output with the model for the current cycle, then advance it.
    task automatic stepModel();
        bit          ev, ew, el, eu;
        logic [95:0] hd;
        logic [23:0] ed;
        ev = (mq.size() != 0);
        hd = ev ? mq[0] : 96'h0;
        ed = ev ? hd[95-24*m_beat -: 24] : 24'h0;
        ew = !rst && (mq.size() != DEPTH);
        el = ev && (m_col == DW-1);
        eu = ev && (m_col == 0) && (m_row == 0);
        checkOutput("m_tvalid",       32'(m_tvalid),       32'(ev));
        checkOutput("m_tdata",        32'(m_tdata),        32'(ed));
        checkOutput("m_tlast",        32'(m_tlast),        32'(el));
        checkOutput("m_tuser",        32'(m_tuser),        32'(eu));
        checkOutput("ac_upsp_wready", 32'(ac_upsp_wready), 32'(ew));
        checkOutput("frame_done",     32'(frame_done),     32'(m_fd));
`ifdef UPSP_SER_PERF_CNT_EN
        checkOutput("stall_in_cnt",   stall_in_cnt,  m_sin);
        checkOutput("stall_out_cnt",  stall_out_cnt, m_sout);
`endif
        last_hs   = !rst && ev && m_tready;
        last_push = !rst && upsp_ac_wvalid && ew;
        if (rst) begin
            mq.delete();
            m_beat = 0; m_col = 0; m_row = 0; m_fd = 1'b0;
            m_sin  = '0; m_sout = '0;
        end else begin
            m_fd = last_hs && (m_col == DW-1) && (m_row == DH-1);
            if (upsp_ac_wvalid && !ew && m_sin != '1) m_sin++;
            if (ev && !m_tready && m_sout != '1) m_sout++;
            if (last_hs) begin
                if (m_beat == 3) begin
                    void'(mq.pop_front());
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
                if (m_col == DW-1) begin
                    m_col = 0;
                    m_row = (m_row == DH-1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
            if (last_push) mq.push_back(upsp_ac_wdata);
        end
        cyc++;
    endtask

    task automatic stepCycle(input logic r, input logic wv, input logic [95:0] wd, input logic tr);
        @(negedge clk);
        rst            = r;
        upsp_ac_wvalid = wv;
        upsp_ac_wdata  = wd;
        m_tready       = tr;
        #1;
        stepModel();
    endtask

    localparam logic [95:0] B1 = 96'h111111_222222_333333_444444;

    initial begin
        int sidx, hs_n, pushed_n, tl_n, tu_n, fd_n;

        vecs[0] = '{1'b1, 96'h0, 1'b0, 1'b1, 24'h0,      1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, B1,    1'b1, 1'b1, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 96'h0, 1'b0, 1'b1, 24'h111111, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 96'h0, 1'b0, 1'b1, 24'h222222, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 96'h0, 1'b0, 1'b1, 24'h333333, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 96'h0, 1'b0, 1'b1, 24'h444444, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 96'h0, 1'b0, 1'b1, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; upsp_ac_wvalid = 1'b0; upsp_ac_wdata = '0; m_tready = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] single bundle vectors");
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        $display("[TB] continuous stream");
        stepCycle(1'b1, 1'b0, 96'h0, 1'b1);
        sidx = 1; hs_n = 0;
        for (int i = 0; i < 40; i++) begin
            stepCycle(1'b0, 1'b1, make_bundle(sidx), 1'b1);
            if (last_push) sidx++;
            if (last_hs) hs_n++;
        end
        checkOutput("stream_gapfree_pixels", 32'(hs_n), 32'd39);

        $display("[TB] output stall at beat 2");
        stepCycle(1'b1, 1'b0, 96'h0, 1'b1);
        stepCycle(1'b0, 1'b1, 96'hAAAAAA_BBBBBB_CCCCCC_DDDDDD, 1'b1);
        stepCycle(1'b0, 1'b0, 96'h0, 1'b1);
        stepCycle(1'b0, 1'b0, 96'h0, 1'b1);
        for (int i = 0; i < 10; i++) stepCycle(1'b0, 1'b1, 96'h123123_456456_789789_ABCABC, 1'b0);
        checkOutput("stall_wready_low", 32'(ac_upsp_wready), 32'd0);
        checkOutput("stall_tdata_held", 32'(m_tdata), 32'h00CCCCCC);
        stepCycle(1'b0, 1'b0, 96'h0, 1'b1);
        checkOutput("resume_tdata", 32'(m_tdata), 32'h00CCCCCC);
`ifdef UPSP_SER_PERF_CNT_EN
        checkOutput("perf_stall_out_10", stall_out_cnt, 32'd10);
        checkOutput("perf_stall_in_9",   stall_in_cnt,  32'd9);
`endif
        repeat (8) stepCycle(1'b0, 1'b0, 96'h0, 1'b1);

        $display("[TB] line and frame markers");
        stepCycle(1'b1, 1'b0, 96'h0, 1'b1);
        pushed_n = 0; tl_n = 0; tu_n = 0; fd_n = 0;
        for (int i = 0; i < 30; i++) begin
            stepCycle(1'b0, pushed_n < 5, make_bundle(200 + pushed_n), 1'b1);
            if (frame_done) fd_n++;
            if (last_hs && m_tlast) tl_n++;
            if (last_hs && m_tuser) tu_n++;
            if (last_push) pushed_n++;
        end
        checkOutput("marker_tlast_count", 32'(tl_n), 32'd2);
        checkOutput("marker_tuser_count", 32'(tu_n), 32'd2);
        checkOutput("marker_frame_done_count", 32'(fd_n), 32'd1);

        $display("[TB] reset mid-frame");
        stepCycle(1'b1, 1'b0, 96'h0, 1'b1);
        pushed_n = 0; hs_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (hs_n == 5) break;
            stepCycle(1'b0, pushed_n < 2, make_bundle(100 + pushed_n), 1'b1);
            if (last_push) pushed_n++;
            if (last_hs) hs_n++;
        end
        checkOutput("midrst_reached_5", 32'(hs_n), 32'd5);
        stepCycle(1'b1, 1'b0, 96'h0, 1'b1);
        stepCycle(1'b0, 1'b0, 96'h0, 1'b1);
        checkOutput("midrst_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("midrst_tdata",  32'(m_tdata),  32'd0);
        checkOutput("midrst_tuser",  32'(m_tuser),  32'd0);
        checkOutput("midrst_wready", 32'(ac_upsp_wready), 32'd1);
        stepCycle(1'b0, 1'b1, 96'h123456_ABCDEF_0F0F0F_F0F0F0, 1'b1);
        stepCycle(1'b0, 1'b0, 96'h0, 1'b1);
        checkOutput("midrst_first_tuser", 32'(m_tuser), 32'd1);
        checkOutput("midrst_first_tdata", 32'(m_tdata), 32'h00123456);
        repeat (4) stepCycle(1'b0, 1'b0, 96'h0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
